// File: rtl/mproc_pkg.sv
// rtl/mproc_pkg.sv - shared widths and loader state encodings for the mproc program memory
package mproc_pkg;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 128;

    // 2'b11 is unused; the loader treats it as a request to restart in LOAD
    typedef enum logic [1:0] {
        LOAD = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } ld_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// rtl/prog_mem_array.sv - DEPTH x DW storage, one synchronous write port, one asynchronous read port
module prog_mem_array #(
    parameter int AW    = 7,
    parameter int DW    = 16,
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write on the rising edge; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational, so a same-cycle write shows up only after the edge
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader that fills program memory and holds mproc in reset until done
module prog_loader #(
    parameter int AW    = mproc_pkg::AW,
    parameter int DW    = mproc_pkg::DW,
    parameter int DEPTH = mproc_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          reload,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          proc_rst_n,
    output logic          busy,
    output logic [AW:0]   word_count
);

    mproc_pkg::ld_state_t state, next_state;
    logic [AW-1:0] wptr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          at_top;

    assign at_top = (wptr == AW'(DEPTH - 1));

    // Next-state decode plus write-port control; ld_ready is purely a state decode
    always_comb begin
        next_state = state;
        we         = 1'b0;
        ld_ready   = 1'b0;
        wdata      = '0;
        case (state)
            mproc_pkg::LOAD: begin
                ld_ready = 1'b1;
                wdata    = ld_data;
                if (ld_valid) begin
                    we = 1'b1;
                    if (at_top) begin
                        next_state = mproc_pkg::RUN;
                    end else if (ld_last) begin
                        next_state = mproc_pkg::FILL;
                    end
                end
            end
            mproc_pkg::FILL: begin
                we = 1'b1;
                if (at_top) begin
                    next_state = mproc_pkg::RUN;
                end
            end
            mproc_pkg::RUN: begin
                if (reload) begin
                    next_state = mproc_pkg::LOAD;
                end
            end
            default: next_state = mproc_pkg::LOAD;
        endcase
    end

    // State, write pointer, image word counter and the registered processor reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= mproc_pkg::LOAD;
            wptr       <= '0;
            word_count <= '0;
            proc_rst_n <= 1'b0;
        end else begin
            state      <= next_state;
            proc_rst_n <= (next_state == mproc_pkg::RUN);
            case (state)
                mproc_pkg::LOAD: begin
                    if (ld_valid) begin
                        word_count <= word_count + 1'b1;
                        // Stop at the top address so the pointer never wraps
                        if (!at_top) begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                mproc_pkg::FILL: begin
                    if (!at_top) begin
                        wptr <= wptr + 1'b1;
                    end
                end
                mproc_pkg::RUN: begin
                    if (reload) begin
                        wptr       <= '0;
                        word_count <= '0;
                    end
                end
                default: begin
                    wptr       <= '0;
                    word_count <= '0;
                end
            endcase
        end
    end

    assign busy = (state != mproc_pkg::RUN);

    prog_mem_array #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: doc/prog_loader.md
# prog_loader

Program memory and boot loader feeding the mproc instruction/data input. It holds a 128 × 16 memory whose asynchronous read port drives mproc `d_in` from mproc `addr`. A valid/ready load port writes a program image into the memory. The loader keeps the processor in reset until the image is complete and every unwritten location has been zero-filled, then releases it.

## Interface
Parameters:
- `AW`, 7, address width; must match mproc `addr`.
- `DW`, 16, data width; must match mproc `d_in`.
- `DEPTH`, 128, number of words; always equals 2^AW.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  load word present.
- `ld_ready`  out  1  loader accepts a word this cycle.
- `ld_data`  in  DW  load word.
- `ld_last`  in  1  qualifies `ld_valid`; marks the final word of the image.
- `reload`  in  1  request a new image; honoured only in RUN.
- `rd_addr`  in  AW  connects to mproc `addr`.
- `rd_data`  out  DW  connects to mproc `d_in`; equals `mem[rd_addr]`.
- `proc_rst_n`  out  1  drives mproc `reset`; active-low.
- `busy`  out  1  high when state is not RUN.
- `word_count`  out  AW+1  number of image words accepted since the last reset or reload (0–128).

## Operation
- States and encodings: LOAD = 2'b00, FILL = 2'b01, RUN = 2'b10. The encoding 2'b11 is illegal; it returns to LOAD on the next edge.
- Reset (while `reset` = 0):
  - state = LOAD, `wptr` = 0, `word_count` = 0, `proc_rst_n` = 0.
  - Memory contents are not cleared.
  - `ld_ready` = 1 and `busy` = 1, because both are decoded from the state.
- LOAD:
  - `ld_ready` = 1.
  - A transfer occurs when `ld_valid` & `ld_ready` are high at a rising edge. On a transfer: `mem[wptr]` ← `ld_data`, `word_count` increments, `wptr` increments.
  - A transfer with `wptr` = 127 goes to RUN, whatever the value of `ld_last`. This applies to the 128th word with or without `ld_last`.
  - Otherwise, a transfer with `ld_last` = 1 goes to FILL, with `wptr` = last address + 1.
  - `ld_valid` low means no write and no state change.
- FILL:
  - `ld_ready` = 0.
  - Each cycle: `mem[wptr]` ← 0, then `wptr` increments.
  - The write at `wptr` = 127 goes to RUN.
  - Duration is 127 − last_addr cycles.
- RUN:
  - `ld_ready` = 0. `ld_valid` is ignored and no memory write occurs.
  - `reload` = 1 at an edge goes to LOAD, with `wptr` = 0, `word_count` = 0, `proc_rst_n` = 0.
  - `reload` is ignored in LOAD and FILL.
- Read port:
  - Combinational in every state: `rd_data` = `mem[rd_addr]`.
  - A read of the address being written in the same cycle returns the old word; the new word appears after the edge.
- Arithmetic:
  - `wptr` is AW bits wide. It never wraps, because the transition to RUN at address 127 is taken before any increment past it.
  - `word_count` is AW+1 bits wide, so a full image reads as 128.

## Timing
- Load throughput: one word per cycle while `ld_valid` is held high. `ld_ready` is not registered.
- `proc_rst_n` is a registered flop: `proc_rst_n` = (next_state == RUN).
  - It rises on the same edge that enters RUN.
  - mproc leaves reset on that edge and fetches `mem[0]` in the following cycle.
- `proc_rst_n` falls on the edge that accepts `reload`, and stays 0 until the next entry into RUN.
- `busy` follows the state directly: it falls on the edge that enters RUN and rises on the edge that leaves it.
- Reset asserted mid-LOAD or mid-FILL:
  - State returns to LOAD immediately and asynchronously, with `proc_rst_n` = 0.
  - A partially written image stays in the memory and is overwritten by the next load.
- Worst-case boot after the first transfer:
  - Single-word image: 1 transfer cycle, then 127 FILL cycles, then `proc_rst_n` rises.
  - Full image: `proc_rst_n` rises on the 128th transfer edge.

## Structure
- Shared package `mproc_pkg` holds:
  - `AW`, `DW`, `DEPTH`;
  - the loader state typedef and encodings (LOAD, FILL, RUN).
- One sub-module, `prog_mem_array`: DEPTH × DW storage with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port.
- The top level contains the FSM, `wptr`, `word_count`, the `proc_rst_n` flop, and a write mux that selects `ld_data` in LOAD and 0 in FILL.

## Test plan
- Reset, then 3 words 16'h1234, 16'h2345, 16'h3456 with `ld_last` on the third:
  - FILL lasts 125 cycles;
  - then `proc_rst_n` = 1 and `busy` = 0;
  - `mem[0..2]` hold the image and `mem[3..127]` read 0;
  - `word_count` = 3.
- 128 back-to-back words, `ld_last` never asserted:
  - RUN is entered on the 128th edge with no FILL;
  - `word_count` = 128;
  - `rd_addr` = 127 returns word 127.
- `ld_valid` toggled 1/0 every cycle during LOAD: only the cycles with `ld_valid` high write, at consecutive addresses; `wptr` holds while `ld_valid` is low.
- In RUN:
  - `ld_valid` = 1 with 16'hFFFF leaves memory unchanged and `ld_ready` = 0;
  - `reload` pulse drops `proc_rst_n` and sets `word_count` = 0 on the same edge;
  - a new 1-word image 16'hABCD then gives `mem[0]` = 16'hABCD and `mem[1..127]` = 0.
- `reset` pulsed low mid-FILL (`wptr` = 40):
  - immediate LOAD with `proc_rst_n` = 0;
  - the reload writes from address 0.
- Connect to mproc, load a 4-instruction program: mproc leaves reset exactly on the RUN edge and its `addr` sequences 0, 1, 2, … while `rd_data` tracks the image.
